// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encodings,
// port identifiers and the default starvation limit.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_A       = 2'd1,
    ST_B       = 2'd2,
    ST_FORCE_B = 2'd3
  } arb_state_t;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_id_t;

  localparam int STARVE_LIMIT_DEFAULT = 4;
  // Wide enough for the largest supported limit (15).
  localparam int STARVE_CNT_W = 4;

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// Saturating count of consecutive cycles in which port B requested but was
// not granted. limit_hit flags that the count reaches LIMIT at the coming
// edge, so the forced B grant lands in the very next cycle.
import dmem_arb_pkg::*;

module dmem_arb_starve_ctr #(
  parameter int LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic limit_hit
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT_CNT = STARVE_CNT_W'(LIMIT);

  logic [STARVE_CNT_W-1:0] count;

  assign limit_hit = inc && (count >= LIMIT_CNT - 1'b1);

  // Count ungranted B-request cycles, clear on a B grant or an idle B.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != LIMIT_CNT)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory. Port A (MEM
// stage) has fixed priority over port B (loader/debug). Read data is
// registered and returned to the winning port one cycle after its grant.
// Build option: define DMEM_ARB_STARVE_EN to add the starvation guard that
// forces a B grant after STARVE_LIMIT consecutive ungranted B-request cycles.
import dmem_arb_pkg::*;

module dmem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_write,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic              b_req,
  input  logic              b_write,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              a_gnt,
  output logic              b_gnt,
  output logic [DATA_W-1:0] a_rdata,
  output logic [DATA_W-1:0] b_rdata,
  output logic              a_rvalid,
  output logic              b_rvalid,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);

  arb_state_t state;
  logic       force_b;
  logic       limit_hit;
  logic       gnt_any;
  port_id_t   gnt_port;

`ifdef DMEM_ARB_STARVE_EN
  assign force_b = (state == ST_FORCE_B);

  dmem_arb_starve_ctr #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve_ctr (
    .clk       (clk),
    .reset     (reset),
    .inc       (b_req & ~b_gnt),
    .clr       (b_gnt | ~b_req),
    .limit_hit (limit_hit)
  );
`else
  // Pure fixed priority: the forced state is never entered.
  assign force_b   = 1'b0;
  assign limit_hit = 1'b0;

  logic unused_cfg;
  assign unused_cfg = ^STARVE_LIMIT;
`endif

  // Grant decision: A wins unless this is the forced B cycle; nothing is
  // granted while reset is held.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (!reset) begin
      if (force_b) begin
        b_gnt = b_req;
      end else begin
        a_gnt = a_req;
        b_gnt = b_req & ~a_req;
      end
    end
  end

  assign gnt_any  = a_gnt | b_gnt;
  assign gnt_port = a_gnt ? PORT_A : PORT_B;

  // Memory mux: the granted port drives the memory, otherwise all zeros.
  always_comb begin
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    if (gnt_any) begin
      case (gnt_port)
        PORT_A: begin
          mem_write      = a_write;
          mem_address    = a_addr;
          mem_write_data = a_wdata;
        end
        default: begin
          mem_write      = b_write;
          mem_address    = b_addr;
          mem_write_data = b_wdata;
        end
      endcase
    end
  end

  // FSM state update and registered read-data return.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      if (limit_hit) begin
        state <= ST_FORCE_B;
      end else if (a_gnt) begin
        state <= ST_A;
      end else if (b_gnt) begin
        state <= ST_B;
      end else begin
        state <= ST_IDLE;
      end

      a_rvalid <= a_gnt & ~a_write;
      b_rvalid <= b_gnt & ~b_write;
      if (a_gnt && !a_write) begin
        a_rdata <= mem_read_data;
      end
      if (b_gnt && !b_write) begin
        b_rdata <= mem_read_data;
      end
    end
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter sharing the single-port `data_memory` between the pipeline MEM stage (port A) and a secondary master such as a loader or debug port (port B). It issues at most one memory access per cycle and gives A fixed priority. An optional starvation guard forces a B grant after a bounded wait. Read data is registered and returned to the winning port one cycle after grant.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `STARVE_LIMIT`, 4, number of consecutive ungranted B-request cycles before a B grant is forced (1..15)
- `clk`  in  1  clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-high reset
- `a_req` / `b_req`  in  1  access request, held until granted
- `a_write` / `b_write`  in  1  1 = write, 0 = read
- `a_addr` / `b_addr`  in  ADDR_W  byte address, forwarded unmodified
- `a_wdata` / `b_wdata`  in  DATA_W  write data
- `a_gnt` / `b_gnt`  out  1  combinational grant; the access completes this cycle
- `a_rdata` / `b_rdata`  out  DATA_W  registered read data
- `a_rvalid` / `b_rvalid`  out  1  one-cycle pulse, cycle after a granted read
- `mem_write`  out  1  to `data_memory.write`
- `mem_address`  out  ADDR_W  to `data_memory.address`
- `mem_write_data`  out  DATA_W  to `data_memory.write_data`
- `mem_read_data`  in  DATA_W  from `data_memory.read_data` (combinational read)

## Operation
- FSM states:
  - ST_IDLE: no grant last cycle.
  - ST_A: A granted last cycle.
  - ST_B: B granted last cycle.
  - ST_FORCE_B: starvation limit reached.
- Grant rule outside ST_FORCE_B: `a_gnt = a_req`; `b_gnt = b_req & ~a_req`.
- Grant rule in ST_FORCE_B: `b_gnt = b_req`; `a_gnt = 0`, which stalls the pipeline.
- Transitions out of any state:
  - A granted: go to ST_A.
  - B granted: go to ST_B.
  - Neither granted: go to ST_IDLE.
  - Starve counter reaches STARVE_LIMIT: go to ST_FORCE_B (takes precedence).
- ST_FORCE_B lasts exactly one grant cycle. If `b_req` drops while in ST_FORCE_B, return to ST_IDLE with no grant.
- Starve counter:
  - Increments on each cycle where `b_req & ~b_gnt`.
  - Clears on a B grant or when `b_req` is low.
  - Saturates at STARVE_LIMIT.
- Memory mux: the granted port drives `mem_address`, `mem_write_data` and `mem_write` (= the port's `_write`).
- Memory idle (no grant): `mem_write = 0`, `mem_address = 0`, `mem_write_data = 0`.
- Read return: on a granted read, `mem_read_data` is captured into that port's `_rdata` at the clock edge. `_rvalid` is high for the following cycle only.
- `_rdata` holds its value until that port's next read completes.
- Granted writes produce no `_rvalid`.
- Same address from both ports in one cycle: only one port is granted. A write by A followed by a read by B returns the new data, since the write commits at the grant edge.

## Timing
- Grant: combinational, zero cycles from `_req` when eligible.
- Write latency: commits at the rising edge ending the grant cycle.
- Read latency: one cycle (grant in cycle N, `_rvalid`/`_rdata` in cycle N+1).
- Throughput: one access per cycle total. Back-to-back grants to the same port are allowed.
- Reset values (asynchronous, immediate):
  - state = ST_IDLE, starve counter = 0.
  - `a_rvalid` = `b_rvalid` = 0; `a_rdata` = `b_rdata` = 0.
  - Grants and `mem_write` are 0 while `reset` is high.
- Reset mid-operation: a pending `_rvalid` is dropped and an in-flight write is not committed by the arbiter.

## Configuration
- `DMEM_ARB_STARVE_EN` defined: the starve counter and ST_FORCE_B are built; B waits at most STARVE_LIMIT cycles.
- Undefined: pure fixed priority. No counter and no ST_FORCE_B; B can starve indefinitely. STARVE_LIMIT is ignored.

## Structure
- Shared package `dmem_arb_pkg`: state encodings (ST_IDLE=0, ST_A=1, ST_B=2, ST_FORCE_B=3), port-id constants PORT_A/PORT_B, default STARVE_LIMIT.
- Sub-module `dmem_arb_starve_ctr`: saturating counter with inputs `clk`, `reset`, `inc`, `clr`; output `limit_hit`. Instantiated only under `DMEM_ARB_STARVE_EN`.

## Test plan
- Memory preloaded with word 3 at address 12; A reads 12 alone -> `a_gnt`=1 same cycle; next cycle `a_rvalid`=1, `a_rdata`=3; `b_rvalid`=0.
- B writes 0 to 20, then B reads 20 -> two consecutive `b_gnt` cycles; `b_rvalid`=1 with `b_rdata`=0 one cycle after the read grant; `mem_write` high only in the write cycle.
- A and B both read 12 in the same cycle -> A granted; B granted the next cycle A is idle; each port gets `_rdata`=3 on its own `_rvalid`.
- With `DMEM_ARB_STARVE_EN` and STARVE_LIMIT=4, A and B requesting continuously -> A granted cycles 0–3; cycle 4 `b_gnt`=1, `a_gnt`=0; A granted again from cycle 5.
- A writes 0x55 to 40 while B reads 40 in the same cycle -> A granted; B granted next cycle; `b_rdata`=0x55.
- `reset` asserted while in ST_FORCE_B with a read pending -> grants and `_rvalid` go to 0 immediately; after release, the first B request waits behind A with the counter at 0.
